alu_rand_stim_gen: RTL and testbench

- Synthesisable, parametrised successor of the ALU random tester: an LFSR-driven generator of ALU transactions (op, A, B).
- Op choice and data values use the same corner-case weighting as the tester: 25% all-zeros, 25% all-ones, 50% random.
- Drives an ALU driver/serializer through a valid/ready port; supports a programmable transaction count, an op-enable mask, seed reload and inter-transaction gaps.
- Sits between the test-control registers and the ALU BFM/driver in emulation and self-test builds.

---
 rtl/alu_stim_pkg.sv | 44 ++++
 rtl/alu_stim_lfsr.sv | 30 +++
 rtl/alu_rand_stim_gen.sv | 228 ++++++++++++++++++++++
 tb/tb_alu_rand_stim_gen.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_stim_pkg.sv
// Shared types, constants and helpers for the ALU random stimulus generator.
package alu_stim_pkg;

    typedef enum logic [2:0] {
        and_op  = 3'd0,
        or_op   = 3'd1,
        add_op  = 3'd2,
        sub_op  = 3'd3,
        op_cor  = 3'd4,
        crc_cor = 3'd5,
        ctl_cor = 3'd6,
        rst_op  = 3'd7
    } operation_t;

    typedef enum logic [1:0] {ZERO, ONES, RAND} data_class_t;

    typedef enum logic [2:0] {IDLE, GEN_OP, GEN_A, GEN_B, OFFER, GAP, DONE} stim_state_t;

    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    // Corner-case weighting: 00 -> zeros, 11 -> ones, the other half random.
    function automatic data_class_t class_of(input logic [1:0] top);
        case (top)
            2'b00:   class_of = ZERO;
            2'b11:   class_of = ONES;
            default: class_of = RAND;
        endcase
    endfunction

    // idx if enabled, else the nearest enabled op above it, wrapping at 8.
    function automatic operation_t pick_op(input logic [7:0] en, input logic [2:0] idx);
        logic [2:0] k;
        pick_op = operation_t'(idx);
        for (int d = 7; d >= 0; d--) begin
            k = idx + 3'(d);
            if (en[k]) pick_op = operation_t'(k);
        end
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], 1'b0} ^ (s[31] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/alu_stim_lfsr.sv
// Loadable 32-bit Galois LFSR; a zero seed is replaced by SEED so the state never locks up.
module alu_stim_lfsr
    import alu_stim_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE1_2021
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_step,
    input  logic        i_load,
    input  logic [31:0] i_seed,
    output logic [31:0] o_state
);

    logic [31:0] r_state;

    // NOTE: sequential state is only ever assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SEED;
        end else if (i_load) begin
            r_state <= (i_seed == 32'h0) ? SEED : i_seed;
        end else if (i_step) begin
            r_state <= lfsr_step(r_state);
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/alu_rand_stim_gen.sv
// LFSR-driven generator of weighted ALU transactions (op, A, B) behind a valid/ready port.
// Define ALU_STIM_COV_EN to build the per-op handshake coverage counters.
module alu_rand_stim_gen
    import alu_stim_pkg::*;
#(
    parameter int          DATA_W     = 32,
    parameter int          CNT_W      = 16,
    parameter int          GAP_CYCLES = 500,
    parameter logic [31:0] LFSR_SEED  = 32'hACE1_2021
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  num_txn,
    input  logic [7:0]        op_en,
    input  logic              seed_ld,
    input  logic [31:0]       seed,
    output logic              txn_valid,
    input  logic              txn_ready,
    output logic [2:0]        txn_op,
    output logic [DATA_W-1:0] txn_a,
    output logic [DATA_W-1:0] txn_b,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  txn_cnt,
    input  logic [2:0]        cov_sel,
    output logic [CNT_W-1:0]  cov_cnt
);

    localparam int WORDS = (DATA_W + 31) / 32;
    localparam int PAD_W = WORDS * 32;
    localparam int WCW   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [WCW-1:0]   WORD_LAST = WCW'(WORDS - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

    stim_state_t       r_state;
    stim_state_t       w_next;
    logic [7:0]        r_op_en;
    logic [CNT_W-1:0]  r_num_txn;
    logic [CNT_W-1:0]  r_txn_cnt;
    logic [WCW-1:0]    r_word;
    logic [GAP_W-1:0]  r_gap;
    data_class_t       r_cls;
    operation_t        r_op;
    logic [PAD_W-1:0]  r_a_full;
    logic [PAD_W-1:0]  r_b_full;
    logic              r_err;
    logic              r_done_zero;

    logic [31:0]       w_lfsr;
    logic              w_step;
    logic              w_load;
    logic              w_start;
    logic              w_hs;
    logic              w_word_last;
    logic [CNT_W-1:0]  w_cnt_inc;
    data_class_t       w_cls;
    logic [31:0]       w_word;
    logic [PAD_W+31:0] w_shift_a;
    logic [PAD_W+31:0] w_shift_b;

    alu_stim_lfsr #(
        .SEED    (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .i_step  (w_step),
        .i_load  (w_load),
        .i_seed  (seed),
        .o_state (w_lfsr)
    );

    assign w_start     = (r_state == IDLE) && start && !seed_ld && !abort;
    assign w_hs        = (r_state == OFFER) && txn_ready;
    assign w_cnt_inc   = r_txn_cnt + 1'b1;
    assign w_word_last = (r_word == WORD_LAST);

    // The class is fixed by the first word of an operand and reused for the rest.
    assign w_cls = (r_word == '0) ? class_of(w_lfsr[31:30]) : r_cls;

    always_comb begin
        case (w_cls)
            ZERO:    w_word = 32'h0000_0000;
            ONES:    w_word = 32'hFFFF_FFFF;
            default: w_word = w_lfsr;
        endcase
    end

    // Words enter at the top and shift down, so after WORDS cycles the first word is the LSW.
    assign w_shift_a = {w_word, r_a_full};
    assign w_shift_b = {w_word, r_b_full};

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next = r_state;
        w_step = 1'b0;
        w_load = 1'b0;
        case (r_state)
            IDLE: begin
                if (seed_ld) begin
                    w_load = 1'b1;
                end else if (start && (op_en != 8'h00) && (num_txn != '0)) begin
                    w_next = GEN_OP;
                end
            end
            GEN_OP: begin
                w_step = 1'b1;
                w_next = GEN_A;
            end
            GEN_A: begin
                w_step = 1'b1;
                if (w_word_last) w_next = GEN_B;
            end
            GEN_B: begin
                w_step = 1'b1;
                if (w_word_last) w_next = OFFER;
            end
            OFFER: begin
                if (txn_ready) begin
                    if (w_cnt_inc == r_num_txn) w_next = DONE;
                    else if (GAP_CYCLES == 0)   w_next = GEN_OP;
                    else                        w_next = GAP;
                end
            end
            GAP: begin
                if (r_gap == GAP_LAST) w_next = GEN_OP;
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
        if (abort) begin
            w_next = IDLE;
            w_load = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_op_en     <= 8'h00;
            r_num_txn   <= '0;
            r_txn_cnt   <= '0;
            r_word      <= '0;
            r_gap       <= '0;
            r_cls       <= ZERO;
            r_op        <= and_op;
            r_a_full    <= '0;
            r_b_full    <= '0;
            r_err       <= 1'b0;
            r_done_zero <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_done_zero <= w_start && (op_en != 8'h00) && (num_txn == '0);

            if (w_start) begin
                if (op_en == 8'h00) begin
                    r_err <= 1'b1;
                end else begin
                    r_err     <= 1'b0;
                    r_txn_cnt <= '0;
                    r_op_en   <= op_en;
                    r_num_txn <= num_txn;
                end
            end

            case (r_state)
                GEN_OP: begin
                    r_op   <= pick_op(r_op_en, w_lfsr[2:0]);
                    r_word <= '0;
                end
                GEN_A, GEN_B: begin
                    if (r_state == GEN_A) r_a_full <= w_shift_a[PAD_W+31:32];
                    else                  r_b_full <= w_shift_b[PAD_W+31:32];
                    r_cls  <= w_cls;
                    r_word <= w_word_last ? '0 : r_word + 1'b1;
                end
                OFFER: begin
                    r_gap <= '0;
                    if (txn_ready) r_txn_cnt <= w_cnt_inc;
                end
                GAP: begin
                    r_gap <= r_gap + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef ALU_STIM_COV_EN
    logic [CNT_W-1:0] r_cov [8];

    // NOTE: the counter array is small and must read zero after reset, so it is reset like any flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) r_cov[i] <= '0;
        end else if (w_start) begin
            for (int i = 0; i < 8; i++) r_cov[i] <= '0;
        end else if (w_hs && (r_cov[r_op] != '1)) begin
            r_cov[r_op] <= r_cov[r_op] + 1'b1;
        end
    end

    assign cov_cnt = r_cov[cov_sel];
`else
    logic w_cov_unused;
    assign w_cov_unused = ^cov_sel ^ w_hs;
    assign cov_cnt      = '0;
`endif

    assign txn_valid = (r_state == OFFER);
    assign txn_op    = r_op;
    assign txn_a     = r_a_full[DATA_W-1:0];
    assign txn_b     = r_b_full[DATA_W-1:0];
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE) || r_done_zero;
    assign err       = r_err;
    assign txn_cnt   = r_txn_cnt;

endmodule

// File: tb/tb_alu_rand_stim_gen.sv
// Randomized scoreboard bench for alu_rand_stim_gen against a transaction-level reference model.
module tb_alu_rand_stim_gen;

    localparam int          DATA_W = 32;
    localparam int          CNT_W  = 16;
    localparam int          GAP    = 2;
    localparam int          WORDS  = (DATA_W + 31) / 32;
    localparam logic [31:0] SEED0  = 32'hACE1_2021;
    localparam logic [31:0] POLY   = 32'h8020_0003;

    typedef struct packed {
        logic [2:0]        op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic [CNT_W-1:0]  num_txn;
    logic [7:0]        op_en;
    logic              seed_ld;
    logic [31:0]       seed;
    logic              txn_valid;
    logic              txn_ready;
    logic [2:0]        txn_op;
    logic [DATA_W-1:0] txn_a;
    logic [DATA_W-1:0] txn_b;
    logic              busy;
    logic              done;
    logic              err;
    logic [CNT_W-1:0]  txn_cnt;
    logic [2:0]        cov_sel;
    logic [CNT_W-1:0]  cov_cnt;

    alu_rand_stim_gen #(
        .DATA_W     (DATA_W),
        .CNT_W      (CNT_W),
        .GAP_CYCLES (GAP),
        .LFSR_SEED  (SEED0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .num_txn   (num_txn),
        .op_en     (op_en),
        .seed_ld   (seed_ld),
        .seed      (seed),
        .txn_valid (txn_valid),
        .txn_ready (txn_ready),
        .txn_op    (txn_op),
        .txn_a     (txn_a),
        .txn_b     (txn_b),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .txn_cnt   (txn_cnt),
        .cov_sel   (cov_sel),
        .cov_cnt   (cov_cnt)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q[$];
    exp_t got_log[$];
    exp_t first_log[$];
    int   op_hits[8];
    int   a_zero;
    int   a_ones;
    logic [31:0] m_lfsr;
    exp_t mon_e;
    exp_t mon_got;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0);
    endfunction

    task automatic model_reseed(input logic [31:0] s);
        m_lfsr = (s == 32'h0) ? SEED0 : s;
    endtask

    task automatic model_operand(output logic [DATA_W-1:0] v);
        logic [WORDS*32-1:0] full;
        logic [1:0]          cls;
        cls = m_lfsr[31:30];
        for (int k = 0; k < WORDS; k++) begin
            if (cls == 2'b00)      full[k*32 +: 32] = 32'h0;
            else if (cls == 2'b11) full[k*32 +: 32] = 32'hFFFF_FFFF;
            else                   full[k*32 +: 32] = m_lfsr;
            m_lfsr = lfsr_next(m_lfsr);
        end
        v = full[DATA_W-1:0];
    endtask

    task automatic model_txn(input logic [7:0] en, output exp_t e);
        int idx;
        bit found;
        idx   = int'(m_lfsr[2:0]);
        m_lfsr = lfsr_next(m_lfsr);
        found = 1'b0;
        e.op  = 3'd0;
        for (int d = 0; d < 8; d++) begin
            if (!found && en[(idx + d) % 8]) begin
                e.op  = 3'((idx + d) % 8);
                found = 1'b1;
            end
        end
        model_operand(e.a);
        model_operand(e.b);
    endtask

    task automatic push_run(input int n, input logic [7:0] en);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            model_txn(en, e);
            q.push_back(e);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst && txn_valid && txn_ready) begin
            mon_got.op = txn_op;
            mon_got.a  = txn_a;
            mon_got.b  = txn_b;
            got_log.push_back(mon_got);
            op_hits[txn_op]++;
            if (txn_a == '0) a_zero++;
            if (txn_a == '1) a_ones++;
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_unexpected: handshake op %0d with nothing expected", txn_op);
            end else begin
                mon_e = q.pop_front();
                check("txn_op", 64'(txn_op), 64'(mon_e.op));
                check("txn_a", 64'(txn_a), 64'(mon_e.a));
                check("txn_b", 64'(txn_b), 64'(mon_e.b));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(output int n, input int budget, input string tag);
        n = 0;
        while (!txn_valid && n < budget) begin
            tick();
            n++;
        end
        if (!txn_valid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_valid_timeout: no txn_valid after %0d cycles", tag, n);
        end
    endtask

    task automatic wait_done(input int exp_cnt, input bit rnd_ready, input int budget, input string tag);
        int n;
        n = 0;
        while (!done && n < budget) begin
            txn_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            n++;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_done_timeout: no done after %0d cycles", tag, n);
        end else begin
            check({tag, "_cnt_at_done"}, 64'(txn_cnt), 64'(exp_cnt));
            tick();
            check({tag, "_done_single"}, 64'(done), 64'(0));
            check({tag, "_idle_busy"}, 64'(busy), 64'(0));
        end
        check({tag, "_sb_drained"}, 64'(q.size()), 64'(0));
    endtask

    task automatic reseed(input logic [31:0] s);
        seed    = s;
        seed_ld = 1'b1;
        tick();
        seed_ld = 1'b0;
        model_reseed(s);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int          n;
        int          diffs;
        logic [7:0]  en;
        exp_t        e;

        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        num_txn   = '0;
        op_en     = 8'h00;
        seed_ld   = 1'b0;
        seed      = 32'h0;
        txn_ready = 1'b0;
        cov_sel   = 3'd0;
        a_zero    = 0;
        a_ones    = 0;
        for (int i = 0; i < 8; i++) op_hits[i] = 0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(txn_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_cnt", 64'(txn_cnt), 64'(0));
        check("rst_op", 64'(txn_op), 64'(0));
        check("rst_a", 64'(txn_a), 64'(0));
        check("rst_b", 64'(txn_b), 64'(0));
        check("rst_cov", 64'(cov_cnt), 64'(0));
        rst = 1'b0;
        model_reseed(SEED0);
        tick();

        // Single op, start latency and gap latency.
        op_en     = 8'h04;
        num_txn   = 16'd3;
        txn_ready = 1'b1;
        push_run(3, 8'h04);
        pulse_start();
        wait_valid(n, 50, "t1");
        check("t1_start_latency", 64'(n), 64'(1 + 2 * WORDS));
        check("t1_op_add", 64'(txn_op), 64'(2));
        tick();
        wait_valid(n, 50, "t1g");
        check("t1_gap_latency", 64'(n), 64'(GAP + 1 + 2 * WORDS));
        wait_done(3, 1'b0, 200, "t1");

        // Backpressure: outputs held while ready is low.
        en        = 8'($urandom_range(1, 255));
        op_en     = en;
        num_txn   = 16'd2;
        txn_ready = 1'b0;
        push_run(2, en);
        pulse_start();
        wait_valid(n, 50, "t2");
        e = q[0];
        for (int i = 0; i < 20; i++) begin
            check("t2_hold_valid", 64'(txn_valid), 64'(1));
            check("t2_hold_op", 64'(txn_op), 64'(e.op));
            check("t2_hold_a", 64'(txn_a), 64'(e.a));
            check("t2_hold_b", 64'(txn_b), 64'(e.b));
            check("t2_hold_cnt", 64'(txn_cnt), 64'(0));
            tick();
        end
        txn_ready = 1'b1;
        tick();
        check("t2_cnt_after_hs", 64'(txn_cnt), 64'(1));
        wait_done(2, 1'b0, 200, "t2");

        // Reproducibility; seed_ld wins over a simultaneous start.
        op_en   = 8'hFF;
        num_txn = 16'd5;
        start   = 1'b1;
        reseed(32'h1);
        start   = 1'b0;
        check("t3_seed_beats_start", 64'(busy), 64'(0));
        en      = 8'($urandom_range(1, 255));
        op_en   = en;
        num_txn = 16'd50;
        got_log.delete();
        push_run(50, en);
        pulse_start();
        wait_done(50, 1'b1, 3000, "t3a");
        first_log = got_log;
        reseed(32'h1);
        got_log.delete();
        push_run(50, en);
        pulse_start();
        wait_done(50, 1'b1, 3000, "t3b");
        check("t3_len", 64'(got_log.size()), 64'(first_log.size()));
        diffs = 0;
        for (int i = 0; i < got_log.size() && i < first_log.size(); i++)
            if (got_log[i] !== first_log[i]) diffs++;
        check("t3_repro_diffs", 64'(diffs), 64'(0));
        reseed(32'h0);
        op_en   = 8'hFF;
        num_txn = 16'd10;
        push_run(10, 8'hFF);
        pulse_start();
        wait_done(10, 1'b1, 1000, "t3z");

        // Edge starts.
        op_en   = 8'h00;
        num_txn = 16'd4;
        pulse_start();
        check("t4_err_set", 64'(err), 64'(1));
        check("t4_err_busy", 64'(busy), 64'(0));
        tick();
        check("t4_err_sticky", 64'(err), 64'(1));
        check("t4_err_idle", 64'(busy), 64'(0));
        check("t4_err_novalid", 64'(txn_valid), 64'(0));
        op_en   = 8'hFF;
        num_txn = 16'd0;
        pulse_start();
        check("t4_zero_done", 64'(done), 64'(1));
        check("t4_zero_busy", 64'(busy), 64'(0));
        check("t4_err_cleared", 64'(err), 64'(0));
        tick();
        check("t4_zero_done_end", 64'(done), 64'(0));
        check("t4_zero_novalid", 64'(txn_valid), 64'(0));

        // Abort in OFFER of the second of five transactions.
        en        = 8'($urandom_range(1, 255));
        op_en     = en;
        num_txn   = 16'd5;
        txn_ready = 1'b1;
        push_run(5, en);
        pulse_start();
        wait_valid(n, 50, "t5a");
        tick();
        txn_ready = 1'b0;
        wait_valid(n, 50, "t5b");
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5_valid_dropped", 64'(txn_valid), 64'(0));
        check("t5_no_done", 64'(done), 64'(0));
        check("t5_idle", 64'(busy), 64'(0));
        check("t5_cnt_held", 64'(txn_cnt), 64'(1));
        tick();
        check("t5_no_done_late", 64'(done), 64'(0));
        q.delete();
        reseed($urandom());

        // Asynchronous reset during GEN_A.
        op_en   = 8'hFF;
        num_txn = 16'd3;
        push_run(3, 8'hFF);
        pulse_start();
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("t5r_valid", 64'(txn_valid), 64'(0));
        check("t5r_busy", 64'(busy), 64'(0));
        check("t5r_done", 64'(done), 64'(0));
        check("t5r_err", 64'(err), 64'(0));
        check("t5r_cnt", 64'(txn_cnt), 64'(0));
        check("t5r_op", 64'(txn_op), 64'(0));
        check("t5r_a", 64'(txn_a), 64'(0));
        check("t5r_b", 64'(txn_b), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        model_reseed(SEED0);
        tick();

        // Distribution over 1000 transactions.
        for (int i = 0; i < 8; i++) op_hits[i] = 0;
        a_zero  = 0;
        a_ones  = 0;
        op_en   = 8'hFF;
        num_txn = 16'd1000;
        push_run(1000, 8'hFF);
        pulse_start();
        wait_done(1000, 1'b0, 12000, "t6");
        for (int i = 0; i < 8; i++) check_range($sformatf("t6_op%0d_count", i), op_hits[i], 80, 170);
        check_range("t6_a_zero_count", a_zero, 200, 300);
        check_range("t6_a_ones_count", a_ones, 200, 300);
        for (int i = 0; i < 8; i++) begin
            cov_sel = 3'(i);
            #1;
`ifdef ALU_STIM_COV_EN
            check($sformatf("t6_cov%0d", i), 64'(cov_cnt), 64'(op_hits[i]));
`else
            check($sformatf("t6_cov%0d_tied", i), 64'(cov_cnt), 64'(0));
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
